// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// Each grant is a burst of at most MAX_BURST beats, and one IDLE cycle separates consecutive grants.
module fifo_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_w_enb_o,
  output logic [WIDTH-1:0]           fifo_d_in_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             grantee_valid;

  // Circular search from last_grant+1; scanning the offsets downward lets the nearest requester win.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid_i[(int'(last_grant_q) + i) % NUM_REQ]) begin
        pick_idx   = IDW'((int'(last_grant_q) + i) % NUM_REQ);
        pick_found = 1'b1;
      end
    end
  end

  assign grantee_valid = req_valid_i[grant_id_q];

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready_o  = '0;
    fifo_w_enb_o = 1'b0;
    fifo_d_in_o  = req_data_i[int'(grant_id_q)*WIDTH +: WIDTH];
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // Reset suppresses the handshake so an abandoned burst never writes.
        req_ready_o[grant_id_q] = !fifo_full_i && !reset_i;
        fifo_w_enb_o            = grantee_valid && !fifo_full_i && !reset_i;
        if (!grantee_valid) begin
          state_d = IDLE;
        end else if (fifo_w_enb_o) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios followed by randomized traffic, checked every cycle against a grant/burst model of the arbiter.
// Inputs are driven just after the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_write_arbiter;

  localparam int WIDTH     = 32;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ*WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]       reqReady;
  logic                     fifoFull;
  logic                     fifoWEnb;
  logic [WIDTH-1:0]         fifoDIn;
  logic [1:0]               grantId;
  logic                     busy;

  int checks = 0;
  int errors = 0;

  bit         mGrant;
  int         mId;
  int         mLast;
  int         mBeats;
  int         sent [NUM_REQ];
  logic [31:0] base [NUM_REQ];
  int         writes;
  logic [31:0] writeData [$];
  int         grantLog [$];

  fifo_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (reqValid),
    .req_data_i   (reqData),
    .req_ready_o  (reqReady),
    .fifo_full_i  (fifoFull),
    .fifo_w_enb_o (fifoWEnb),
    .fifo_d_in_o  (fifoDIn),
    .grant_id_o   (grantId),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model past the rising edge.
  task automatic applyStimulus(input bit rst, input logic [NUM_REQ-1:0] valid, input bit full);
    bit               expWenb;
    logic [NUM_REQ-1:0] expReady;
    reset    = rst;
    reqValid = valid;
    fifoFull = full;
    for (int i = 0; i < NUM_REQ; i++) reqData[i*WIDTH +: WIDTH] = base[i] + 32'(sent[i]);
    #1;
    expWenb  = mGrant && valid[mId] && !full && !rst;
    expReady = (mGrant && !full && !rst) ? (NUM_REQ'(1) << mId) : '0;
    checkOutput("busy", 64'(busy), 64'(mGrant));
    checkOutput("grant_id", 64'(grantId), 64'(mId));
    checkOutput("w_enb", 64'(fifoWEnb), 64'(expWenb));
    checkOutput("req_ready", 64'(reqReady), 64'(expReady));
    if (expWenb) checkOutput("d_in", 64'(fifoDIn), 64'(base[mId] + 32'(sent[mId])));
    if (fifoWEnb === 1'b1) begin
      writes++;
      writeData.push_back(fifoDIn);
    end
    @(posedge clk);
    if (expWenb) sent[mId]++;
    if (rst) begin
      mGrant = 0; mId = 0; mLast = NUM_REQ - 1; mBeats = 0;
    end else if (!mGrant) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (mLast + k) % NUM_REQ;
        if (valid[c]) begin
          mId = c; mLast = c; mBeats = 0; mGrant = 1;
          grantLog.push_back(c);
          break;
        end
      end
    end else if (!valid[mId]) begin
      mGrant = 0;
    end else if (!full) begin
      mBeats++;
      if (mBeats == MAX_BURST) mGrant = 0;
    end
    @(negedge clk);
  endtask

  task automatic clearLog();
    writes = 0;
    writeData.delete();
    grantLog.delete();
  endtask

  initial begin
    logic [NUM_REQ-1:0] rv;
    bit                 rf;
    bit                 rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      sent[i] = 0;
      base[i] = 32'h1000_0000 * (i + 1);
    end
    base[0] = 32'hA0;
    reset = 1'b1; reqValid = '0; fifoFull = 1'b0; reqData = '0;
    mGrant = 0; mId = 0; mLast = NUM_REQ - 1; mBeats = 0;
    @(negedge clk); @(negedge clk);
    clearLog();

    $display("[TB] reset state");
    applyStimulus(1, 4'b0000, 0);
    checkOutput("reset_grant_id", 64'(grantId), 64'd0);

    $display("[TB] single requester");
    clearLog();
    for (int c = 0; c < 10; c++) applyStimulus(0, 4'b0001, 0);
    applyStimulus(0, 4'b0000, 0);
    checkOutput("single_writes", 64'(writes), 64'd8);
    for (int k = 0; k < 8; k++)
      checkOutput("single_data", (k < writeData.size()) ? 64'(writeData[k]) : 64'hDEAD, 64'(32'hA0 + k));

    $display("[TB] all requesting");
    applyStimulus(1, 4'b0000, 0);
    clearLog();
    for (int c = 0; c < 20; c++) applyStimulus(0, 4'b1111, 0);
    checkOutput("all_writes_20", 64'(writes), 64'd16);
    applyStimulus(0, 4'b1111, 0);
    checkOutput("all_grants", 64'(grantLog.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      checkOutput("all_order", (k < grantLog.size()) ? 64'(grantLog[k]) : 64'hDEAD, 64'(k % NUM_REQ));

    $display("[TB] early release");
    applyStimulus(0, 4'b0000, 0);
    clearLog();
    for (int c = 0; c < 3; c++) applyStimulus(0, 4'b0100, 0);
    applyStimulus(0, 4'b0000, 0);
    checkOutput("early_writes", 64'(writes), 64'd2);
    checkOutput("early_idle", 64'(busy), 64'd0);
    clearLog();
    for (int c = 0; c < 6; c++) applyStimulus(0, 4'b0100, 0);
    checkOutput("early_regrant_writes", 64'(writes), 64'd4);
    applyStimulus(0, 4'b0000, 0);

    $display("[TB] back-pressure");
    clearLog();
    applyStimulus(0, 4'b0010, 0);
    applyStimulus(0, 4'b0010, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 4'b0010, 1);
      checkOutput("bp_grant_id", 64'(grantId), 64'd1);
    end
    for (int c = 0; c < 3; c++) applyStimulus(0, 4'b0010, 0);
    checkOutput("bp_writes", 64'(writes), 64'd4);
    applyStimulus(0, 4'b0000, 0);

    $display("[TB] reset mid-burst");
    clearLog();
    applyStimulus(0, 4'b1000, 0);
    applyStimulus(0, 4'b1000, 0);
    applyStimulus(1, 4'b1000, 0);
    checkOutput("rst_writes", 64'(writes), 64'd1);
    applyStimulus(0, 4'b1000, 0);
    checkOutput("rst_regrant3", 64'(grantId), 64'd3);
    applyStimulus(0, 4'b1000, 0);
    applyStimulus(1, 4'b1111, 0);
    applyStimulus(0, 4'b1111, 0);
    checkOutput("rst_grant0", 64'(grantId), 64'd0);
    applyStimulus(0, 4'b0000, 0);

    $display("[TB] skip non-requesters");
    applyStimulus(0, 4'b0010, 0);
    applyStimulus(0, 4'b0000, 0);
    clearLog();
    applyStimulus(0, 4'b0001, 0);
    checkOutput("skip_grant", 64'(grantId), 64'd0);
    checkOutput("skip_busy", 64'(busy), 64'd1);
    applyStimulus(0, 4'b0001, 0);
    checkOutput("skip_write", 64'(writes), 64'd1);
    applyStimulus(0, 4'b0000, 0);

    $display("[TB] randomized traffic");
    rv = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) rv = NUM_REQ'($urandom);
      rf = ($urandom_range(3) == 0);
      rr = ($urandom_range(49) == 0);
      applyStimulus(rr, rv, rf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO w_enb/d_in pins.
- The arbiter honours FIFO full back-pressure.
- It sits directly in front of the FIFO write side; the read side is untouched.

Parameters:
- WIDTH, 32: data width; must match the FIFO WIDTH.
- NUM_REQ, 4: number of requesters, >= 2.
- MAX_BURST, 4: maximum beats written per grant, >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*WIDTH  requester i data is on bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit set.
- fifo_full  input  1  FIFO full flag.
- fifo_w_enb  output  1  FIFO write enable.
- fifo_d_in  output  WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of the current grantee; holds its last value when idle.
- busy  output  1  high while in state GRANT.

Behaviour:
- Reset (synchronous, takes priority over all other activity):
  - state = IDLE, grant_id = 0, last_grant = NUM_REQ-1, beat_cnt = 0.
  - req_ready = 0, fifo_w_enb = 0, busy = 0.
  - If reset is asserted mid-burst, the burst is abandoned and no write occurs in that cycle.
- State IDLE:
  - If any req_valid bit is set, choose the first set bit searching circularly from last_grant+1.
  - Register the choice into grant_id and last_grant, clear beat_cnt, and go to GRANT.
  - With no requests, stay in IDLE.
  - Arbitration latency is 1 cycle: no write is issued in IDLE.
- State GRANT:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits = 0.
  - fifo_w_enb = req_valid[grant_id] && !fifo_full (combinational). No write is ever issued while fifo_full = 1.
  - fifo_d_in = the req_data slice for grant_id, driven combinationally. It is don't-care when fifo_w_enb = 0.
  - A transfer is a cycle with fifo_w_enb = 1. Each transfer increments beat_cnt; beat_cnt is $clog2(MAX_BURST+1) bits wide.
  - Go to IDLE when either:
    - a transfer occurs with beat_cnt == MAX_BURST-1 (burst complete), or
    - req_valid[grant_id] = 0 (requester done).
  - A cycle with fifo_full = 1 and valid high is a stall: the grant is held and beat_cnt is unchanged. There is no timeout.
- One IDLE bubble cycle always separates consecutive grants, including re-granting the same requester.
- Fairness:
  - Round robin over grants, not beats.
  - A continuously requesting producer waits at most NUM_REQ-1 grants.
- Requesters must hold req_data stable while valid is high and ready is low. The arbiter does not buffer data.
- busy = (state == GRANT).

Test Plan (NUM_REQ=4, WIDTH=32, MAX_BURST=4):
1. Single requester:
   - Stimulus: after reset, req_valid = 0001 held; req 0 data = 0xA0..0xA7 in sequence.
   - Required: grant_id = 0; writes 0xA0..0xA3 on 4 consecutive cycles, then 1 IDLE cycle, then 0xA4..0xA7.
2. All requesting:
   - Stimulus: req_valid = 1111 continuously.
   - Required: grant order 0,1,2,3,0; each grant is exactly 4 writes; a 1-cycle bubble between grants; 16 writes in 20 cycles.
3. Early release:
   - Stimulus: req 2 is the only requester; it drops valid after 2 beats.
   - Required: exactly 2 writes, then IDLE. On the next request from req 2 it is re-granted with beat_cnt restarting at 0.
4. Back-pressure:
   - Stimulus: fifo_full = 1 for 3 cycles in mid-burst (after beat 1) while req 1 is granted.
   - Required: w_enb = 0 and req_ready = 0 during those 3 cycles; grant_id stays 1; the remaining 3 beats complete after full deasserts.
5. Reset mid-burst:
   - Stimulus: reset asserted for 1 cycle during beat 2 of req 3.
   - Required: no write in that cycle; next cycle busy = 0 and req_ready = 0; with req_valid = 1000 the next grant goes to req 3; with 1111 it goes to req 0.
6. Skip non-requesters:
   - Stimulus: last_grant = 1 and req_valid = 0001.
   - Required: the search wraps past 2 and 3 and grants 0 after the 1-cycle arbitration latency.
